// File: rtl/time_counter_gen.sv
// time_counter_gen: BCD time-of-day counter.
// State is kept as canonical 24-hour BCD (hour 00-23, minute 00-59, second 00-59).
// The 12-hour view is applied only on the outputs and when interpreting loads.
module time_counter_gen #(
    parameter bit SEC_EN = 1'b0
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       tick,
    input  logic       mode_12h,
    input  logic       load_new,
    input  logic [3:0] new_ms_hr,
    input  logic [3:0] new_ls_hr,
    input  logic [3:0] new_ms_min,
    input  logic [3:0] new_ls_min,
    input  logic [3:0] new_ms_sec,
    input  logic [3:0] new_ls_sec,
    input  logic       new_pm,
    input  logic       adj_hr,
    input  logic       adj_min,
    output logic [3:0] ms_hr,
    output logic [3:0] ls_hr,
    output logic [3:0] ms_min,
    output logic [3:0] ls_min,
    output logic [3:0] ms_sec,
    output logic [3:0] ls_sec,
    output logic       pm,
    output logic       day_wrap,
    output logic       load_err
);

    // Packed BCD fields: [7:4] tens digit, [3:0] units digit.
    logic [7:0] hr_reg, hr_next;
    logic [7:0] min_reg, min_next;
    logic [7:0] sec_reg, sec_next;
    logic       day_wrap_reg, day_wrap_next;
    logic       load_err_reg, load_err_next;

    // Binary 0..23 to two BCD digits.
    function automatic logic [7:0] to_bcd(input logic [7:0] v);
        logic [3:0] tens;
        tens = (v >= 8'd20) ? 4'd2 : (v >= 8'd10) ? 4'd1 : 4'd0;
        return {tens, 4'(v - 8'(tens) * 8'd10)};
    endfunction

    // BCD increment modulo 60 (minutes and seconds).
    function automatic logic [7:0] inc_mod60(input logic [7:0] v);
        if (v[3:0] == 4'd9)
            return (v[7:4] == 4'd5) ? 8'h00 : {v[7:4] + 4'd1, 4'd0};
        return {v[7:4], v[3:0] + 4'd1};
    endfunction

    // BCD increment modulo 24 (hours); 09->10 and 19->20 carry into the tens digit.
    function automatic logic [7:0] inc_hr(input logic [7:0] v);
        if (v == 8'h23)
            return 8'h00;
        if (v[3:0] == 4'd9)
            return {v[7:4] + 4'd1, 4'd0};
        return {v[7:4], v[3:0] + 4'd1};
    endfunction

    logic       digits_ok;
    logic       hour_ok;
    logic [7:0] new_hr_bin;
    logic [7:0] canon_hr_bin;

    // Load validation and conversion of a 12-hour load to canonical hour.
    always_comb begin
        new_hr_bin = 8'(new_ms_hr) * 8'd10 + 8'(new_ls_hr);
        digits_ok  = (new_ms_hr <= 4'd9) && (new_ls_hr <= 4'd9) &&
                     (new_ms_min <= 4'd5) && (new_ls_min <= 4'd9) &&
                     (!SEC_EN || ((new_ms_sec <= 4'd5) && (new_ls_sec <= 4'd9)));
        hour_ok    = mode_12h ? ((new_hr_bin >= 8'd1) && (new_hr_bin <= 8'd12))
                              : (new_hr_bin <= 8'd23);
        canon_hr_bin = new_hr_bin;
        if (mode_12h) begin
            if (new_hr_bin == 8'd12)
                canon_hr_bin = new_pm ? 8'd12 : 8'd0;
            else if (new_pm)
                canon_hr_bin = new_hr_bin + 8'd12;
        end
    end

    // Next state: load beats adjust beats tick; losers in the same cycle are dropped.
    always_comb begin
        hr_next       = hr_reg;
        min_next      = min_reg;
        sec_next      = sec_reg;
        day_wrap_next = 1'b0;
        load_err_next = 1'b0;
        if (load_new) begin
            if (digits_ok && hour_ok) begin
                hr_next  = to_bcd(canon_hr_bin);
                min_next = {new_ms_min, new_ls_min};
                sec_next = SEC_EN ? {new_ms_sec, new_ls_sec} : 8'h00;
            end else begin
                load_err_next = 1'b1;
            end
        end else if (adj_hr || adj_min) begin
            if (adj_min) begin
                min_next = inc_mod60(min_reg);
                sec_next = 8'h00;
            end
            if (adj_hr)
                hr_next = inc_hr(hr_reg);
        end else if (tick) begin
            if (SEC_EN)
                sec_next = inc_mod60(sec_reg);
            // Without seconds the tick feeds the minute field directly.
            if (!SEC_EN || (sec_reg == 8'h59)) begin
                min_next = inc_mod60(min_reg);
                if (min_reg == 8'h59) begin
                    hr_next = inc_hr(hr_reg);
                    if (hr_reg == 8'h23)
                        day_wrap_next = 1'b1;
                end
            end
        end
    end

    // State register with synchronous reset to 00:00:00 and no pending pulses.
    always_ff @(posedge clk) begin
        if (reset) begin
            hr_reg       <= 8'h00;
            min_reg      <= 8'h00;
            sec_reg      <= 8'h00;
            day_wrap_reg <= 1'b0;
            load_err_reg <= 1'b0;
        end else begin
            hr_reg       <= hr_next;
            min_reg      <= min_next;
            sec_reg      <= sec_next;
            day_wrap_reg <= day_wrap_next;
            load_err_reg <= load_err_next;
        end
    end

    logic [7:0] hr_bin;
    logic [7:0] disp_hr;

    // Display mapping: 12-hour view shows 00 as 12 and 13-23 as 01-11.
    always_comb begin
        hr_bin  = 8'(hr_reg[7:4]) * 8'd10 + 8'(hr_reg[3:0]);
        disp_hr = hr_reg;
        if (mode_12h) begin
            if (hr_bin == 8'd0)
                disp_hr = 8'h12;
            else if (hr_bin > 8'd12)
                disp_hr = to_bcd(hr_bin - 8'd12);
        end
    end

    assign ms_hr    = disp_hr[7:4];
    assign ls_hr    = disp_hr[3:0];
    assign ms_min   = min_reg[7:4];
    assign ls_min   = min_reg[3:0];
    assign ms_sec   = sec_reg[7:4];
    assign ls_sec   = sec_reg[3:0];
    assign pm       = (hr_bin >= 8'd12);
    assign day_wrap = day_wrap_reg;
    assign load_err = load_err_reg;

endmodule

// File: doc/time_counter_gen.md
# time_counter_gen

Parametrised BCD time-of-day counter, the next-generation replacement for the four-digit alarm-clock counter. It adds an optional seconds field, a run-time 12/24-hour display mode with PM flag, and validated loads. It also provides single-step hour/minute adjust inputs for the set-time keypad path and a day-rollover pulse for downstream date or alarm logic. It sits between the timing generator (which supplies the tick) and the display driver/alarm comparator.

## Interface
- SEC_EN, 0: 1 = HH:MM:SS with tick = one second; 0 = HH:MM with tick = one minute, seconds digits held at 0.
- clk  in  1  system clock; all state changes on posedge.
- reset  in  1  synchronous, active-high reset.
- tick  in  1  count enable, one-cycle pulse per second (SEC_EN=1) or minute (SEC_EN=0).
- mode_12h  in  1  0 = 24-hour interpretation of loads and outputs; 1 = 12-hour.
- load_new  in  1  load request for the new_* digits.
- new_ms_hr, new_ls_hr, new_ms_min, new_ls_min, new_ms_sec, new_ls_sec  in  4 each  BCD load value; sec digits ignored when SEC_EN=0.
- new_pm  in  1  PM flag for loads in 12-hour mode; ignored in 24-hour mode.
- adj_hr  in  1  increment hour by one, no carry into other fields.
- adj_min  in  1  increment minute by one, no carry into hours.
- ms_hr, ls_hr, ms_min, ls_min, ms_sec, ls_sec  out  4 each  current time, BCD.
- pm  out  1  1 when the canonical hour is 12–23, in both modes.
- day_wrap  out  1  one-cycle pulse on a tick-driven 23:59(:59)→00:00(:00) rollover.
- load_err  out  1  one-cycle pulse when a load was rejected.

## Operation
- State is held in canonical 24-hour BCD registers: hour 00–23, min 00–59, sec 00–59.
- Outputs are combinational from the state registers and mode_12h.
  - 24h: hour digits are passed through.
  - 12h: canonical 00 displays as 12; 13–23 display as 01–11; 01–12 are unchanged.
- Priority per cycle: reset > load_new > adjust > tick. A lower-priority request in the same cycle is dropped, not deferred.
- Reset: all digits 0 (00:00:00); day_wrap=0, load_err=0. In 12h mode the display shows 12:00, pm=0.
- Load validation:
  - Every digit must be ≤9; ms_min ≤5; ms_sec ≤5 (SEC_EN=1).
  - Hour must be 00–23 in 24h mode, or 01–12 in 12h mode.
  - A valid 12h load is converted to canonical form: 12 AM→00, 12 PM→12, h PM→h+12.
  - Valid load: all fields are replaced. With SEC_EN=0, seconds are forced to 0.
  - Invalid load: state is unchanged and load_err=1 for the next cycle.
- Adjust:
  - adj_min: minute +1 modulo 60 (59→00); seconds cleared; hour unchanged.
  - adj_hr: hour +1 modulo 24 (23→00); minutes and seconds unchanged.
  - Both asserted together: both apply in the same cycle.
  - Adjust never raises day_wrap.
- Tick count (with full BCD carry chain):
  - ls_sec 9→0 carries into ms_sec; 59 s→00 carries into minutes (SEC_EN=1 only).
  - ls_min 9→0 carries into ms_min; 59 min→00 carries into hours.
  - ls_hr 9→0 carries into ms_hr (09→10, 19→20); 23→00 wraps and raises day_wrap.
  - With SEC_EN=0, the tick drives minutes directly.
- mode_12h may change at any time. It affects only the display and load interpretation, never the state.

## Timing
- All updates take effect on the posedge where the request is sampled high. Outputs show the new value in the following cycle (one-cycle latency, no pipeline).
- day_wrap and load_err are registered. Each is high for exactly the one cycle after the causing edge and is otherwise 0.
- A tick held high for N cycles advances the count N times. Edge detection is the tick source's job.
- Reset asserted mid-count, or in the same cycle as load_new, tick or adjust: reset wins and no pulse is generated.
- A tick coinciding with load_new is lost. A valid load of 23:59 followed by a tick on the next cycle gives 00:00 with day_wrap.

## Test plan
- SEC_EN=0: reset, load 09:59, one tick → 10:00; load 23:59, tick → 00:00 with day_wrap high for exactly one cycle.
- SEC_EN=1: load 12:59:59, tick → 13:00:00. With mode_12h=1, outputs read 01:00:00, pm=1.
- 12h loads: 12 AM → canonical 00, outputs 12, pm=0. 12 PM → pm=1. Load 13 in 12h mode, or 24 in 24h mode → load_err pulse, state unchanged.
- Invalid digits: min=60 or ls_hr=0xA → load_err=1 for one cycle, state unchanged. Valid load of 07:45 → load_err stays 0.
- Adjust: at 23:59:30, adj_min → 23:00:00 with no hour carry and no day_wrap. At 23:00:00, adj_hr → 00:00:00. adj_hr and adj_min together at 10:10 → 11:11.
- Priority: reset together with load_new and tick → 00:00:00, no pulses. load_new (08:00) together with tick → 08:00, tick dropped.
